// File: rtl/td4_inst_encoder.sv
// TD4 instruction encoder: mnemonic stream -> FIFO -> sequential program writes.
// Optional self-loop HALT word after drain when TD4_ENC_AUTO_HALT_EN is defined.
module td4_inst_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int PROG_WORDS = 16
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       start,
  input  logic       end_prog,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_mnem,
  input  logic [3:0] in_imm,
  output logic       wr_en,
  input  logic       wr_ready,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [4:0] words,
  output logic       done,
  output logic       err_illegal
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [4:0] PW = 5'(PROG_WORDS);
  localparam logic [CW-1:0] FD = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_cnt;
  logic          r_full;
  logic [4:0]    r_acc;
  logic [3:0]    r_addr;
  logic [4:0]    r_words;
  logic          r_err;
  logic          r_end;

  logic          w_legal;
  logic          w_zimm;
  logic [3:0]    w_op;
  logic [7:0]    w_word;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_nxt;
  logic [3:0]    w_addr_inc;

  always_comb begin
    w_legal = 1'b1;
    w_zimm  = 1'b0;
    w_op    = 4'b0000;
    case (in_mnem)
      4'd0:  w_op = 4'b0000;
      4'd1:  begin w_op = 4'b0001; w_zimm = 1'b1; end
      4'd2:  begin w_op = 4'b0010; w_zimm = 1'b1; end
      4'd3:  w_op = 4'b0011;
      4'd4:  begin w_op = 4'b0100; w_zimm = 1'b1; end
      4'd5:  w_op = 4'b0101;
      4'd7:  w_op = 4'b0111;
      4'd8:  begin w_op = 4'b1001; w_zimm = 1'b1; end
      4'd9:  w_op = 4'b1011;
      4'd10: w_op = 4'b1110;
      4'd11: w_op = 4'b1111;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_word = {w_op, w_zimm ? 4'h0 : in_imm};

  // Registered full flag keeps push off a full FIFO even when a pop is due.
  assign in_ready = (r_state == S_RUN) && !r_full &&
                    (r_acc < PW) && !r_end;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && w_legal;

  assign wr_en = ((r_state == S_RUN) && (r_cnt != '0)) ||
                 (r_state == S_HALT);
  assign w_pop = (r_state == S_RUN) && (r_cnt != '0) && wr_ready;

  assign wr_data = (r_state == S_HALT) ? {4'hF, r_addr} :
                   (wr_en ? r_mem[r_rd] : 8'h00);

  assign w_cnt_nxt  = r_cnt + CW'(w_push) - CW'(w_pop);
  assign w_addr_inc = (r_addr == 4'hF) ? r_addr : r_addr + 4'd1;

  assign wr_addr     = r_addr;
  assign words       = r_words;
  assign done        = (r_state == S_DONE);
  assign err_illegal = r_err;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_acc   <= '0;
      r_addr  <= '0;
      r_words <= '0;
      r_err   <= 1'b0;
      r_end   <= 1'b0;
    end else if (start) begin
      r_state <= S_RUN;
      r_rd    <= '0;
      r_wr    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_acc   <= '0;
      r_addr  <= '0;
      r_words <= '0;
      r_err   <= 1'b0;
      r_end   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_push) begin
            r_mem[r_wr] <= w_word;
            r_wr  <= r_wr + 1'b1;
            r_acc <= r_acc + 5'd1;
          end
          if (w_accept && !w_legal) r_err <= 1'b1;
          if (w_pop) begin
            r_rd    <= r_rd + 1'b1;
            r_addr  <= w_addr_inc;
            r_words <= r_words + 5'd1;
          end
          r_cnt  <= w_cnt_nxt;
          r_full <= (w_cnt_nxt == FD);
          if (end_prog) r_end <= 1'b1;
          // Neither condition can coincide with a push: in_ready is low.
          if (r_cnt == '0 && (r_end || r_words == PW)) begin
`ifdef TD4_ENC_AUTO_HALT_EN
            r_state <= (r_end && r_words < PW) ? S_HALT : S_DONE;
`else
            r_state <= S_DONE;
`endif
          end
        end
        S_HALT: begin
          if (wr_ready) begin
            r_addr  <= w_addr_inc;
            r_words <= r_words + 5'd1;
            r_state <= S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_td4_inst_encoder.sv
// Directed bench for td4_inst_encoder.
// Writes are captured into a local program image and checked against constants.
module tb_td4_inst_encoder;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       start = 1'b0;
  logic       end_prog = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_mnem = 4'd0;
  logic [3:0] in_imm = 4'd0;
  logic       wr_en;
  logic       wr_ready = 1'b0;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] words;
  logic       done;
  logic       err_illegal;

  int checks = 0;
  int errors = 0;
  logic [7:0] cap [16];
  int ncap = 0;

  td4_inst_encoder dut (
    .clk(clk), .n_reset(n_reset), .start(start),
    .end_prog(end_prog), .in_valid(in_valid),
    .in_ready(in_ready), .in_mnem(in_mnem),
    .in_imm(in_imm), .wr_en(wr_en),
    .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .words(words), .done(done),
    .err_illegal(err_illegal)
  );

  always #5 clk = ~clk;

  // Program memory model: a write lands on the rising edge after this sample.
  always begin
    @(negedge clk);
    #1;
    if (n_reset && !start && wr_en === 1'b1 && wr_ready === 1'b1) begin
      cap[wr_addr] = wr_data;
      ncap++;
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clr_cap();
    for (int i = 0; i < 16; i++) cap[i] = 8'h00;
    ncap = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    clr_cap();
  endtask

  task automatic push(input logic [3:0] m, input logic [3:0] i);
    int n;
    in_valid = 1'b1;
    in_mnem = m;
    in_imm = i;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: done=%b required 1", done);
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    cycles(2);
    checks++;
    if ({in_ready, wr_en, wr_addr, wr_data, words, done, err_illegal}
        !== 21'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b wen=%b a=%h d=%h w=%0d dn=%b e=%b required all 0",
               in_ready, wr_en, wr_addr, wr_data, words, done, err_illegal);
    end
    n_reset = 1'b1;
    cycles(1);
    checks++;
    if (in_ready !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: in_ready=%b wr_en=%b required 0 0", in_ready, wr_en);
    end
  endtask

  task automatic test_basic();
    wr_ready = 1'b1;
    pulse_start();
    push(4'd3, 4'd5);
    push(4'd0, 4'd1);
    push(4'd11, 4'd0);
    cycles(3);
    checks++;
    if (cap[0] !== 8'h35 || cap[1] !== 8'h01 || cap[2] !== 8'hF0) begin
      errors++;
      $display("FAIL basic_words: got %h %h %h required 35 01 f0", cap[0], cap[1], cap[2]);
    end
    checks++;
    if (words !== 5'd3 || wr_addr !== 4'd3) begin
      errors++;
      $display("FAIL basic_count: words=%0d addr=%0d required 3 3", words, wr_addr);
    end
  endtask

  task automatic test_imm_and_illegal();
    push(4'd1, 4'd7);
    cycles(2);
    checks++;
    if (cap[3] !== 8'h10) begin
      errors++;
      $display("FAIL forced_imm: got %h required 10", cap[3]);
    end
    checks++;
    if (err_illegal !== 1'b0) begin
      errors++;
      $display("FAIL err_early: err_illegal=%b required 0", err_illegal);
    end
    push(4'd6, 4'd3);
    cycles(3);
    checks++;
    if (err_illegal !== 1'b1 || words !== 5'd4 || ncap !== 4) begin
      errors++;
      $display("FAIL illegal_drop: err=%b words=%0d writes=%0d required 1 4 4",
               err_illegal, words, ncap);
    end
  endtask

  task automatic test_backpressure();
    wr_ready = 1'b0;
    pulse_start();
    push(4'd3, 4'd1);
    checks++;
    if (wr_en !== 1'b1 || wr_data !== 8'h31) begin
      errors++;
      $display("FAIL latency: wr_en=%b data=%h required 1 31", wr_en, wr_data);
    end
    push(4'd3, 4'd2);
    push(4'd3, 4'd3);
    push(4'd3, 4'd4);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: in_ready=%b required 0", in_ready);
    end
    cycles(3);
    checks++;
    if (wr_en !== 1'b1 || wr_data !== 8'h31 || wr_addr !== 4'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold: wen=%b d=%h a=%0d rdy=%b required 1 31 0 0",
               wr_en, wr_data, wr_addr, in_ready);
    end
    wr_ready = 1'b1;
    cycles(6);
    checks++;
    if (cap[0] !== 8'h31 || cap[1] !== 8'h32 || cap[2] !== 8'h33 ||
        cap[3] !== 8'h34 || words !== 5'd4) begin
      errors++;
      $display("FAIL drain: %h %h %h %h words=%0d required 31 32 33 34 4",
               cap[0], cap[1], cap[2], cap[3], words);
    end
  endtask

  task automatic test_full_program();
    logic [3:0] k;
    wr_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      k = 4'(i);
      push(4'd9, k);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL cap16_ready: in_ready=%b required 0", in_ready);
    end
    wait_done(20);
    checks++;
    if (wr_addr !== 4'd15 || words !== 5'd16 || ncap !== 16 ||
        cap[0] !== 8'hB0 || cap[15] !== 8'hBF) begin
      errors++;
      $display("FAIL full_prog: a=%0d w=%0d n=%0d c0=%h c15=%h required 15 16 16 b0 bf",
               wr_addr, words, ncap, cap[0], cap[15]);
    end
    checks++;
    if (in_ready !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL done_quiet: in_ready=%b wr_en=%b required 0 0", in_ready, wr_en);
    end
  endtask

  task automatic test_end_prog();
    wr_ready = 1'b1;
    pulse_start();
    push(4'd0, 4'd1);
    push(4'd5, 4'd2);
    push(4'd7, 4'd3);
    end_prog = 1'b1;
    @(negedge clk);
    end_prog = 1'b0;
    wait_done(20);
    cycles(1);
`ifdef TD4_ENC_AUTO_HALT_EN
    checks++;
    if (cap[3] !== 8'hF3 || words !== 5'd4 || ncap !== 4 || wr_addr !== 4'd4) begin
      errors++;
      $display("FAIL auto_halt: c3=%h w=%0d n=%0d a=%0d required f3 4 4 4",
               cap[3], words, ncap, wr_addr);
    end
`else
    checks++;
    if (words !== 5'd3 || ncap !== 3 || wr_addr !== 4'd3) begin
      errors++;
      $display("FAIL end_done: w=%0d n=%0d a=%0d required 3 3 3", words, ncap, wr_addr);
    end
`endif
    checks++;
    if (cap[0] !== 8'h01 || cap[1] !== 8'h52 || cap[2] !== 8'h73) begin
      errors++;
      $display("FAIL end_words: %h %h %h required 01 52 73", cap[0], cap[1], cap[2]);
    end
    end_prog = 1'b1;
    @(negedge clk);
    end_prog = 1'b0;
    cycles(2);
    checks++;
    if (done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL end_in_done: done=%b in_ready=%b required 1 0", done, in_ready);
    end
  endtask

  task automatic test_start_flush();
    wr_ready = 1'b0;
    pulse_start();
    push(4'd3, 4'd9);
    push(4'd12, 4'd0);
    push(4'd3, 4'd8);
    checks++;
    if (err_illegal !== 1'b1 || wr_en !== 1'b1) begin
      errors++;
      $display("FAIL pre_flush: err=%b wen=%b required 1 1", err_illegal, wr_en);
    end
    start = 1'b1;
    end_prog = 1'b1;
    @(negedge clk);
    start = 1'b0;
    end_prog = 1'b0;
    checks++;
    if (wr_en !== 1'b0 || wr_addr !== 4'd0 || words !== 5'd0 ||
        err_illegal !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: wen=%b a=%0d w=%0d e=%b dn=%b rdy=%b required 0 0 0 0 0 1",
               wr_en, wr_addr, words, err_illegal, done, in_ready);
    end
  endtask

  task automatic test_async_reset();
    wr_ready = 1'b0;
    pulse_start();
    push(4'd3, 4'd6);
    #2;
    n_reset = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || words !== 5'd0 || wr_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: wen=%b w=%0d d=%h required 0 0 00", wr_en, words, wr_data);
    end
    @(negedge clk);
    n_reset = 1'b1;
    cycles(1);
  endtask

  initial begin
    clr_cap();
    test_reset();
    test_basic();
    test_imm_and_illegal();
    test_backpressure();
    test_full_program();
    test_end_prog();
    test_start_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
